mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Load/store adapter between the CPU memory stage and the byte-addressed async-read RAM.
//  Accepts one load/store per valid/ready handshake. Aligns and masks stores onto the RAM write port.
//  Reads loads through a RAM read port, then extracts and sign/zero-extends the selected lane.
//  Returns a registered response with an error flag for misaligned, out-of-range or illegal-size accesses.
// PARAMETERS
//  NUM_BYTES   (1<<21)  RAM size in bytes; must match the RAM instance.
//  DATA_WIDTH  32       word width; fixed at 32 for MIPS32.
//  ADDR_WIDTH  $clog2(NUM_BYTES), localparam; width of the RAM address.
// PORTS
//  clk         in   1    clock
//  reset       in   1    asynchronous, active-high reset
//  req_valid   in   1    request valid
//  req_ready   out  1    unit can accept a request; high only in IDLE
//  req_wen     in   1    1=store, 0=load
//  req_size    in   2    0=byte, 1=half, 2=word, 3=illegal
//  req_signed  in   1    loads only: sign-extend (1) or zero-extend (0)
//  req_addr    in   32   byte address
//  req_wdata   in   32   store data, right-justified
//  resp_valid  out  1    response valid
//  resp_ready  in   1    consumer accepts the response
//  resp_rdata  out  32   load result (0 for stores and errors)
//  resp_err    out  1    access faulted; no RAM write happened
//  mem_waddr   out  ADDR_WIDTH  word-aligned write address (to dw_addr)
//  mem_wdata   out  32   lane-replicated store data (to dw_data)
//  mem_wmask   out  4    byte mask; bit i writes byte addr+i (to dw_mask)
//  mem_wen     out  1    write strobe, one cycle (to dw_en)
//  mem_raddr   out  ADDR_WIDTH  word-aligned read address (to dataInstr_1_addr)
//  mem_rdata   in   32   async read data; byte i = mem[raddr+i]
// BEHAVIOUR
//  Reset (async): state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, mem_wen=0,
//   mem_wmask=0, mem_waddr=0, mem_wdata=0, mem_raddr=0, and the request register is cleared.
//  A request is accepted on the edge where req_valid&&req_ready; fields go into the request register.
//  FSM states: IDLE, READ, WRITE, RESP.
//   IDLE : on accept -> RESP if faulted; else WRITE if req_wen; else READ.
//   WRITE: mem_wen=1 for exactly this cycle -> RESP.
//   READ : mem_raddr is driven this cycle; mem_rdata is lane-extracted into resp_rdata -> RESP.
//   RESP : resp_valid=1 with stable data; resp_valid&&resp_ready -> IDLE.
//  req_ready=(state==IDLE). No back-to-back acceptance, so the unit has at most 1 outstanding request.
//  Latency from accept edge N:
//   load/store: resp_valid from edge N+2.
//   fault: resp_valid from edge N+1.
//  Fault when any of: size==3; half with addr[0]!=0; word with addr[1:0]!=0; addr>=NUM_BYTES.
//   On fault: resp_err=1, resp_rdata=0, no mem_wen pulse.
//  Store lane rules, with off=addr[1:0] and waddr=addr[ADDR_WIDTH-1:0]&~3:
//   byte: mask=4'b0001<<off, wdata={4{b}}.
//   half: mask=4'b0011<<off, wdata={2{h}}.
//   word: mask=4'b1111.
//  Load extract: byte = rdata[8*off+:8]; half = rdata[8*off+:16]; then extend per req_signed.
//   Word loads ignore req_signed.
//  Outputs outside their active state: mem_wen=0 and resp_valid=0; address and data outputs hold.
//  Reset mid-operation aborts the request. A pending write never issues after reset; a response is never presented.
//  resp_ready has no effect outside RESP. req_* inputs are ignored outside IDLE.
// STRUCTURE
//  lsu_pkg: mem_size_e {SZ_B,SZ_H,SZ_W,SZ_BAD}, lsu_state_e, LANE_BYTES=4 constant.
//  Sub-module lsu_lane_align (combinational):
//   store side: size, off and wdata -> mask and replicated data.
//   load side: size, off, signed and rdata -> extended result.
//  The top level holds the FSM, the request register and the response register.
// TESTING
//  Store then load, word: SW 0xDEADBEEF @0x100, then LW @0x100.
//   -> mask=1111, waddr=0x100; rdata=0xDEADBEEF, err=0.
//  Byte store: SB 0x1234_5680 @0x103.
//   -> waddr=0x100, mask=1000, wdata=0x80808080.
//   LB @0x103 -> 0xFFFFFF80; LBU @0x103 -> 0x00000080.
//  Half load: LH @0x102 over memory word 0x8001_7FFF -> 0xFFFF8001; LHU -> 0x00008001.
//  Faults: LW @0x102, SH @0x101, size=3 and addr=NUM_BYTES.
//   -> resp_valid at N+1 with err=1 and rdata=0; mem_wen never pulses.
//  Backpressure: hold resp_ready=0 for 5 cycles.
//   -> resp_valid and data stay stable; req_ready=0; a second req_valid is not accepted.
//  Reset asserted during WRITE/READ.
//   -> outputs take their reset values immediately; no mem_wen pulse; no resp_valid afterwards.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and the captured request.
// Pure declarations; no timing or flow-control behaviour lives here.
package lsu_pkg;

   localparam int LANE_BYTES = 4;

   typedef enum logic [1:0] {
      SZ_B   = 2'd0,
      SZ_H   = 2'd1,
      SZ_W   = 2'd2,
      SZ_BAD = 2'd3
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_RESP
   } lsu_state_e;

   // Only what the load-extract step needs later; everything else is consumed at accept.
   typedef struct packed {
      mem_size_e  size;
      logic       sgn;
      logic [1:0] off;
   } req_t;

   function automatic logic misaligned(input mem_size_e size, input logic [1:0] off);
      case (size)
         SZ_H:    return off[0];
         SZ_W:    return off != 2'b00;
         SZ_BAD:  return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store mask/replication and load extract/extend. Purely combinational,
// zero latency, no flow control.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  mem_size_e                 st_size,
   input  logic [1:0]                st_off,
   input  logic [8*LANE_BYTES-1:0]   st_wdata,
   output logic [LANE_BYTES-1:0]     st_mask,
   output logic [8*LANE_BYTES-1:0]   st_data,
   input  mem_size_e                 ld_size,
   input  logic [1:0]                ld_off,
   input  logic                      ld_signed,
   input  logic [8*LANE_BYTES-1:0]   ld_rdata,
   output logic [8*LANE_BYTES-1:0]   ld_result
);

   logic [8*LANE_BYTES-1:0] ld_shift;

   always_comb begin
      st_mask = '0;
      st_data = st_wdata;
      case (st_size)
         SZ_B: begin
            st_mask = 4'b0001 << st_off;
            st_data = {4{st_wdata[7:0]}};
         end
         SZ_H: begin
            st_mask = 4'b0011 << st_off;
            st_data = {2{st_wdata[15:0]}};
         end
         SZ_W:    st_mask = 4'b1111;
         default: st_mask = '0;
      endcase
   end

   // Shift the addressed lane down to bit 0, then extend.
   always_comb begin
      ld_shift  = ld_rdata >> {ld_off, 3'b000};
      ld_result = ld_rdata;
      case (ld_size)
         SZ_B:    ld_result = {{24{ld_signed & ld_shift[7]}}, ld_shift[7:0]};
         SZ_H:    ld_result = {{16{ld_signed & ld_shift[15]}}, ld_shift[15:0]};
         default: ld_result = ld_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// CPU load/store adapter onto an async-read RAM; response 2 cycles after accept (1 for faults).
// One request outstanding: req_ready only in IDLE; the response holds until resp_ready.
module mem_access_unit
   import lsu_pkg::*;
#(
   parameter  int NUM_BYTES  = 1 << 21,
   parameter  int DATA_WIDTH = 32,
   localparam int ADDR_WIDTH = $clog2(NUM_BYTES)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wen,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_wmask,
   output logic                  mem_wen,
   output logic [ADDR_WIDTH-1:0] mem_raddr,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   lsu_state_e            state_q, state_d;
   req_t                  req_q, req_d;
   logic                  resp_valid_q, resp_valid_d;
   logic                  resp_err_q, resp_err_d;
   logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
   logic [ADDR_WIDTH-1:0] mem_waddr_q, mem_waddr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]            mem_wmask_q, mem_wmask_d;
   logic                  mem_wen_q, mem_wen_d;
   logic [ADDR_WIDTH-1:0] mem_raddr_q, mem_raddr_d;

   mem_size_e             in_size;
   logic                  in_fault;
   logic [ADDR_WIDTH-1:0] in_word_addr;
   logic [3:0]            st_mask;
   logic [DATA_WIDTH-1:0] st_data;
   logic [DATA_WIDTH-1:0] ld_result;

   assign in_size      = mem_size_e'(req_size);
   assign in_fault     = misaligned(in_size, req_addr[1:0]) ||
                         ({1'b0, req_addr} >= 33'(NUM_BYTES));
   assign in_word_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};

   // Store side steers the live request; load side works from the captured request.
   lsu_lane_align u_align (
      .st_size   (in_size),
      .st_off    (req_addr[1:0]),
      .st_wdata  (req_wdata),
      .st_mask   (st_mask),
      .st_data   (st_data),
      .ld_size   (req_q.size),
      .ld_off    (req_q.off),
      .ld_signed (req_q.sgn),
      .ld_rdata  (mem_rdata),
      .ld_result (ld_result)
   );

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      resp_valid_d = 1'b0;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      mem_waddr_d  = mem_waddr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wmask_d  = mem_wmask_q;
      mem_wen_d    = 1'b0;
      mem_raddr_d  = mem_raddr_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               req_d = '{size: in_size, sgn: req_signed, off: req_addr[1:0]};
               if (in_fault) begin
                  state_d      = ST_RESP;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else if (req_wen) begin
                  state_d     = ST_WRITE;
                  mem_wen_d   = 1'b1;
                  mem_waddr_d = in_word_addr;
                  mem_wdata_d = st_data;
                  mem_wmask_d = st_mask;
               end else begin
                  state_d     = ST_READ;
                  mem_raddr_d = in_word_addr;
               end
            end
         end
         ST_WRITE: begin
            state_d      = ST_RESP;
            resp_err_d   = 1'b0;
            resp_rdata_d = '0;
         end
         ST_READ: begin
            state_d      = ST_RESP;
            resp_err_d   = 1'b0;
            resp_rdata_d = ld_result;
         end
         ST_RESP: begin
            // First RESP cycle loads the response register; valid rises on the next edge.
            if (resp_valid_q && resp_ready) begin
               state_d = ST_IDLE;
            end else begin
               resp_valid_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         req_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         mem_waddr_q  <= '0;
         mem_wdata_q  <= '0;
         mem_wmask_q  <= '0;
         mem_wen_q    <= 1'b0;
         mem_raddr_q  <= '0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         mem_waddr_q  <= mem_waddr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wmask_q  <= mem_wmask_d;
         mem_wen_q    <= mem_wen_d;
         mem_raddr_q  <= mem_raddr_d;
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_waddr  = mem_waddr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wmask  = mem_wmask_q;
   assign mem_wen    = mem_wen_q;
   assign mem_raddr  = mem_raddr_q;

endmodule
